int8_mlp_layer_seq: RTL and testbench
=====================================

INT8_MLP_LAYER_SEQ -- requirements
Module: int8_mlp_layer_seq

Interface
REQ-001 SHALL have parameter IN, default 8: input vector length, and the dot-product width.
REQ-002 SHALL have parameter OUT, default 4: number of output neurons, at least 1.
REQ-003 SHALL have parameter SHIFT, default 7: requantization right-shift amount, 0..31.
REQ-004 clk  input  1  rising-edge clock; the only clock in the block.
REQ-005 rst  input  1  reset; synchronous to clk and active-high.
REQ-006 in_valid  input  1  input vector x is valid.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 in_x  input  IN x 8 signed  input activations.
REQ-009 w_addr  output  $clog2(OUT) (minimum 1)  weight and bias row address.
REQ-010 w_rdata  input  IN x 8 signed  weight row; valid one cycle after w_addr is presented.
REQ-011 b_rdata  input  32 signed  bias for the row; same one-cycle latency as w_rdata.
REQ-012 out_valid  output  1  result is valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_y  output  8 signed  requantized neuron output.
REQ-015 out_idx  output  $clog2(OUT) (minimum 1)  neuron index of out_y.
REQ-016 out_last  output  1  out_y belongs to neuron OUT-1.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement a four-state FSM with states IDLE, FETCH, CALC and EMIT.
REQ-019 in_ready SHALL be 1 only in IDLE; a transfer is the cycle where in_valid and in_ready are both 1.
REQ-020 On transfer: latch in_x into x_reg, set neuron counter n to 0, next state FETCH.
REQ-021 FETCH SHALL drive w_addr = n for one cycle, next state CALC.
REQ-022 In CALC, sum SHALL be the signed 32-bit dot of x_reg and w_rdata plus b_rdata, computed in 33 bits with no wrap.
REQ-023 CALC SHALL register the result of REQ-024..026 into out_y, register n into out_idx, next state EMIT.
REQ-024 Requantize step 1 (ReLU): if sum < 0 the result is 0.
REQ-025 Requantize step 2: otherwise the result is sum arithmetically shifted right by SHIFT.
REQ-026 Requantize step 3: a shifted value above 127 SHALL saturate to 127; the output range is 0..127.
REQ-027 In EMIT, out_valid SHALL be 1 and out_y, out_idx and out_last SHALL hold stable until the handshake.
REQ-028 On EMIT with out_ready=1 and n < OUT-1: increment n, next state FETCH.
REQ-029 On EMIT with out_ready=1 and n = OUT-1: next state IDLE; no wrap of n.
REQ-030 Latency: first out_valid SHALL be 3 cycles after the input transfer; each later neuron follows 3 cycles after the previous handshake.
REQ-031 Throughput: one neuron per 3 cycles with no backpressure.
REQ-032 Backpressure (out_ready=0) SHALL hold the block in EMIT indefinitely with no loss or change of data.
REQ-033 in_valid in any non-IDLE state SHALL be ignored and x_reg SHALL NOT change.
REQ-034 w_addr SHALL be 0 in IDLE and SHALL hold its value in all other states.

Reset
REQ-035 While rst=1 the block SHALL enter IDLE, including mid-layer.
REQ-036 Under rst, n, out_y, out_idx and x_reg SHALL reset to 0.
REQ-037 Under rst, out_valid, out_last and busy SHALL reset to 0 and in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-038 Reset mid-layer SHALL emit no partial results afterwards.

Structure
REQ-039 A shared package int8_mlp_pkg SHALL hold the FSM state enum, the sat_relu_shift function and the INT8_MAX=127 constant.
REQ-040 The CALC arithmetic SHALL instantiate the team's combinational sub-module int8_dot (IN, x, w, acc).
REQ-041 The bias add and requantization SHALL be local to this block, not in int8_dot.

Verification (IN=8, OUT=4, SHIFT=7)
REQ-042 x=all 1; row0 w=all 16, bias 0 -> out_y=1, out_idx=0, out_valid exactly 3 cycles after the input transfer.
REQ-043 row1 w=all -16, bias 0 -> sum=-128, out_y=0 (ReLU).
REQ-044 x=all 127; row2 w=all 127, bias 0 -> sum=129032, out_y=127 (saturated).
REQ-045 row3 w=all 0, bias=640 -> out_y=5, out_last=1, then in_ready=1 the next cycle.
REQ-046 Hold out_ready=0 for 10 cycles at neuron 1 -> out_y, out_idx and out_valid are stable; 4 results arrive in order 0..3.
REQ-047 Pulse rst in CALC of neuron 2 -> IDLE next cycle, out_valid=0, no further outputs; a new vector then yields results 0..3 correctly.

Source files
------------

// File: rtl/int8_mlp_pkg.sv
// Shared types and requantization helper for the int8 MLP layer datapath.
package int8_mlp_pkg;

  localparam int INT8_MAX = 127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CALC  = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

  // ReLU, arithmetic right shift, then clamp to 0..INT8_MAX.
  function automatic logic [7:0] sat_relu_shift(input logic signed [32:0] sum,
                                                input int unsigned       shift);
    logic signed [32:0] shifted;
    logic [7:0]         result;
    shifted = sum >>> shift;
    if (sum[32]) begin
      result = '0;
    end else if (shifted > 33'(INT8_MAX)) begin
      result = 8'(INT8_MAX);
    end else begin
      result = shifted[7:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/int8_dot.sv
// Combinational signed int8 dot product of two IN-element vectors.
module int8_dot #(
  parameter int IN = 8
) (
  input  logic        [IN-1:0][7:0] x,
  input  logic        [IN-1:0][7:0] w,
  output logic signed [31:0]        acc
);

  // NOTE: blocking assignments in combinational logic, so each loop step sees the previous partial sum.
  always_comb begin
    acc = '0;
    for (int i = 0; i < IN; i++) begin
      acc = acc + 32'($signed(x[i])) * 32'($signed(w[i]));
    end
  end

endmodule

// File: rtl/int8_mlp_layer_seq.sv
// Sequential int8 fully-connected layer: one neuron per FETCH/CALC/EMIT pass
// over an externally stored weight/bias table with one-cycle read latency.
module int8_mlp_layer_seq
  import int8_mlp_pkg::*;
#(
  parameter  int IN    = 8,
  parameter  int OUT   = 4,
  parameter  int SHIFT = 7,
  localparam int AW    = (OUT > 1) ? $clog2(OUT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [IN-1:0][7:0] in_x,
  output logic        [AW-1:0]      w_addr,
  input  logic        [IN-1:0][7:0] w_rdata,
  input  logic signed [31:0]        b_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [7:0]         out_y,
  output logic        [AW-1:0]      out_idx,
  output logic                     out_last,
  output logic                     busy
);

  localparam logic [AW-1:0] LAST_N = AW'(OUT - 1);

  state_e                   state_q, state_d;
  logic        [IN-1:0][7:0] x_q, x_d;
  logic        [AW-1:0]      n_q, n_d;
  logic        [AW-1:0]      w_addr_q, w_addr_d;
  logic signed [7:0]         out_y_q, out_y_d;
  logic        [AW-1:0]      out_idx_q, out_idx_d;
  logic                     out_last_q, out_last_d;

  logic signed [31:0]        acc;
  logic signed [32:0]        sum;

  int8_dot #(.IN(IN)) u_dot (
    .x   (x_q),
    .w   (w_rdata),
    .acc (acc)
  );

  // One extra bit so bias + dot product never wraps before the ReLU test.
  assign sum = 33'(acc) + 33'(b_rdata);

  // NOTE: every next-state signal defaults to its register value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    n_d        = n_q;
    w_addr_d   = w_addr_q;
    out_y_d    = out_y_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d      = in_x;
          n_d      = '0;
          w_addr_d = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_CALC;
      end
      ST_CALC: begin
        out_y_d    = sat_relu_shift(sum, SHIFT);
        out_idx_d  = n_q;
        out_last_d = (n_q == LAST_N);
        state_d    = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (n_q == LAST_N) begin
            w_addr_d   = '0;
            out_last_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            n_d      = n_q + AW'(1);
            w_addr_d = n_q + AW'(1);
            state_d  = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      n_q        <= '0;
      w_addr_q   <= '0;
      out_y_q    <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      n_q        <= n_d;
      w_addr_q   <= w_addr_d;
      out_y_q    <= out_y_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_EMIT);
  assign w_addr    = w_addr_q;
  assign out_y     = out_y_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_int8_mlp_layer_seq.sv
// Self-checking bench for int8_mlp_layer_seq against an arithmetic reference model.
module tb_int8_mlp_layer_seq;

  localparam int IN    = 8;
  localparam int OUT   = 4;
  localparam int SHIFT = 7;
  localparam int AW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic        [IN-1:0][7:0] in_x;
  logic        [AW-1:0]      w_addr;
  logic        [IN-1:0][7:0] w_rdata;
  logic signed [31:0]        b_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [7:0]         out_y;
  logic        [AW-1:0]      out_idx;
  logic                     out_last;
  logic                     busy;

  byte x_vec [IN];
  byte w_mem [OUT][IN];
  int  b_mem [OUT];
  int  fixed_y [OUT];
  bit  use_fixed;

  int checks = 0;
  int errors = 0;

  int8_mlp_layer_seq #(.IN(IN), .OUT(OUT), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .b_rdata   (b_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Synchronous weight/bias table: data appears one cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < IN; i++) w_rdata[i] <= w_mem[w_addr][i];
    b_rdata <= b_mem[w_addr];
  end

  function automatic int model_y(input int k);
    longint s;
    s = longint'(b_mem[k]);
    for (int i = 0; i < IN; i++) s += longint'(x_vec[i]) * longint'(w_mem[k][i]);
    if (s < 0) return 0;
    s = s / (longint'(1) << SHIFT);
    if (s > 127) return 127;
    return int'(s);
  endfunction

  task automatic randomize_layer();
    for (int i = 0; i < IN; i++) x_vec[i] = byte'($urandom);
    for (int k = 0; k < OUT; k++) begin
      for (int i = 0; i < IN; i++) w_mem[k][i] = byte'($urandom);
      b_mem[k] = int'($urandom_range(0, 60000)) - 30000;
    end
  endtask

  task automatic transfer();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_before_transfer: got %b expected 1", in_ready);
    end
    for (int i = 0; i < IN; i++) in_x[i] = x_vec[i];
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = {$urandom, $urandom};
  endtask

  // Sends x_vec, then collects OUT results; stall_len cycles of backpressure
  // (with in_valid noise) at neuron stall_idx, optional random stalls elsewhere.
  task automatic run_layer(input int stall_idx, input int stall_len, input bit rand_stall);
    int cyc, exp_y, stall;
    logic signed [7:0] y0;
    logic [AW-1:0] idx0;
    bit stable;
    transfer();
    cyc = 1;
    for (int k = 0; k < OUT; k++) begin
      while (out_valid !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != 3) begin
        errors++;
        $display("FAIL latency_n%0d: got %0d cycles expected 3", k, cyc);
      end
      exp_y = use_fixed ? fixed_y[k] : model_y(k);
      checks++;
      if (out_y !== 8'(exp_y)) begin
        errors++;
        $display("FAIL out_y_n%0d: got %0d expected %0d", k, out_y, exp_y);
      end
      checks++;
      if (out_idx !== AW'(k)) begin
        errors++;
        $display("FAIL out_idx_n%0d: got %0d expected %0d", k, out_idx, k);
      end
      checks++;
      if (out_last !== (k == OUT - 1)) begin
        errors++;
        $display("FAIL out_last_n%0d: got %b expected %b", k, out_last, (k == OUT - 1));
      end
      stall = (k == stall_idx) ? stall_len : (rand_stall ? int'($urandom_range(0, 3)) : 0);
      if (stall > 0) begin
        y0     = out_y;
        idx0   = out_idx;
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
          out_ready = 1'b0;
          in_valid  = 1'b1;
          in_x      = {$urandom, $urandom};
          @(negedge clk);
          if (out_valid !== 1'b1 || out_y !== y0 || out_idx !== idx0 || busy !== 1'b1)
            stable = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (!stable) begin
          errors++;
          $display("FAIL stall_hold_n%0d: got valid=%b y=%0d idx=%0d expected valid=1 y=%0d idx=%0d",
                   k, out_valid, out_y, out_idx, y0, idx0);
        end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      cyc = 1;
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || w_addr !== '0) begin
      errors++;
      $display("FAIL idle_after_layer: got ready=%b busy=%b valid=%b addr=%0d expected 1 0 0 0",
               in_ready, busy, out_valid, w_addr);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_x      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (out_y !== 8'sd0) begin errors++; $display("FAIL reset_out_y: got %0d expected 0", out_y); end
    checks++;
    if (out_idx !== '0) begin errors++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++;
    if (w_addr !== '0) begin errors++; $display("FAIL reset_w_addr: got %0d expected 0", w_addr); end
  endtask

  task automatic test_directed();
    for (int i = 0; i < IN; i++) begin
      w_mem[0][i] = 8'sd16;
      w_mem[1][i] = -8'sd16;
      w_mem[2][i] = 8'sd127;
      w_mem[3][i] = 8'sd0;
    end
    b_mem[0] = 0; b_mem[1] = 0; b_mem[2] = 0; b_mem[3] = 640;
    use_fixed = 1'b1;
    for (int i = 0; i < IN; i++) x_vec[i] = 8'sd1;
    fixed_y[0] = 1; fixed_y[1] = 0; fixed_y[2] = 7; fixed_y[3] = 5;
    run_layer(-1, 0, 1'b0);
    for (int i = 0; i < IN; i++) x_vec[i] = 8'sd127;
    fixed_y[0] = 127; fixed_y[1] = 0; fixed_y[2] = 127; fixed_y[3] = 5;
    run_layer(-1, 0, 1'b0);
    use_fixed = 1'b0;
  endtask

  task automatic test_backpressure();
    randomize_layer();
    run_layer(1, 10, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 8; v++) begin
      randomize_layer();
      run_layer(-1, 0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_layer();
    bit quiet;
    randomize_layer();
    transfer();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 20 && out_valid !== 1'b1; c++) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || w_addr !== AW'(2)) begin
      errors++;
      $display("FAIL calc_n2_reached: got busy=%b valid=%b addr=%0d expected 1 0 2", busy, out_valid, w_addr);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        out_y !== 8'sd0 || out_idx !== '0 || w_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: got ready=%b busy=%b valid=%b y=%0d idx=%0d expected 1 0 0 0 0",
               in_ready, busy, out_valid, out_y, out_idx);
    end
    out_ready = 1'b1;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    out_ready = 1'b0;
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL no_partial_after_reset: got out_valid=1 expected 0");
    end
    randomize_layer();
    run_layer(-1, 0, 1'b1);
  endtask

  initial begin
    use_fixed = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_layer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
